mem_port_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch and the load/store path, as set up by the decode control unit. Grants one requester at a time and holds the transaction until memory acknowledges. Generates byte enables and store-data lane replication for SB/SH/SW, and sign- or zero-extends LB/LH/LW/LBU/LHU results. Rejects misaligned or illegal accesses without touching memory. A fairness counter stops back-to-back data accesses from starving fetch.

---
 rtl/mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between instruction fetch and the
//             load/store path. Grants one requester at a time, holds the
//             memory transaction until mem_ack, builds byte enables and
//             lane-replicated store data, extends load results, rejects
//             misaligned/illegal accesses without touching memory, and
//             bounds consecutive data grants while fetch is waiting.
//  Ports    : clk, rst (async, active-high)
//             if_req/if_addr            -> if_ready/if_rdata
//             ls_req/ls_we/ls_funct3/ls_addr/ls_wdata
//                                        -> ls_ready/ls_rdata/ls_err
//             mem_req/mem_we/mem_be/mem_addr/mem_wdata <- mem_ack/mem_rdata
//             busy : arbiter is in FETCH or DATA
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int                 c_CNT_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_DATA_BURST);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;

    logic [1:0]         r_state, w_next_state;
    logic [c_CNT_W-1:0] r_cnt, w_cnt;

    // Access attributes captured at grant, used to shape the load result.
    logic [2:0]  r_f3,  w_f3;
    logic [1:0]  r_alo, w_alo;
    logic        r_we,  w_we;

    logic        r_if_ready,  w_if_ready;
    logic [31:0] r_if_rdata,  w_if_rdata;
    logic        r_ls_ready,  w_ls_ready;
    logic [31:0] r_ls_rdata,  w_ls_rdata;
    logic        r_ls_err,    w_ls_err;
    logic        r_mem_req,   w_mem_req;
    logic        r_mem_we,    w_mem_we;
    logic [3:0]  r_mem_be,    w_mem_be;
    logic [31:0] r_mem_addr,  w_mem_addr;
    logic [31:0] r_mem_wdata, w_mem_wdata;
    logic        r_busy;

    // Fetch addresses are word aligned by construction; low bits are dropped.
    logic w_unused;
    assign w_unused = &{1'b0, if_addr[1:0]};

    // ------------------------------------------------------------------
    // Arbitration and access legality
    // ------------------------------------------------------------------
    logic w_data_win, w_fetch_win, w_f3_bad, w_misalign, w_ls_bad;

    assign w_data_win  = ls_req && (!if_req || (r_cnt < c_CNT_MAX));
    assign w_fetch_win = if_req && !w_data_win;

    // funct3[1:0]=11 is never legal; bit 2 (unsigned) is illegal for stores
    // and for word loads.
    assign w_f3_bad   = (ls_funct3[1:0] == 2'b11) ||
                        (ls_funct3[2] && (ls_we || ls_funct3[1]));
    assign w_misalign = ((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
                        ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
    assign w_ls_bad   = w_f3_bad || w_misalign;

    // Store lane generation.
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    always_comb begin
        w_st_be   = 4'b1111;
        w_st_data = ls_wdata;
        case (ls_funct3[1:0])
            2'b00: begin
                w_st_be   = 4'b0001 << ls_addr[1:0];
                w_st_data = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be   = 4'b0011 << {ls_addr[1], 1'b0};
                w_st_data = {2{ls_wdata[15:0]}};
            end
            default: begin
                w_st_be   = 4'b1111;
                w_st_data = ls_wdata;
            end
        endcase
    end

    // Load extraction: shifting by the byte offset puts the addressed byte
    // or (aligned) halfword at bit 0.
    logic [31:0] w_shift, w_load_val;
    assign w_shift = mem_rdata >> {r_alo, 3'b000};
    always_comb begin
        w_load_val = mem_rdata;
        case (r_f3)
            3'b000:  w_load_val = {{24{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_load_val = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_val = {24'd0, w_shift[7:0]};
            3'b101:  w_load_val = {16'd0, w_shift[15:0]};
            default: w_load_val = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // State register (also holds every registered output)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_f3        <= 3'd0;
            r_alo       <= 2'd0;
            r_we        <= 1'b0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_ls_ready  <= 1'b0;
            r_ls_rdata  <= 32'd0;
            r_ls_err    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt;
            r_f3        <= w_f3;
            r_alo       <= w_alo;
            r_we        <= w_we;
            r_if_ready  <= w_if_ready;
            r_if_rdata  <= w_if_rdata;
            r_ls_ready  <= w_ls_ready;
            r_ls_rdata  <= w_ls_rdata;
            r_ls_err    <= w_ls_err;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_be    <= w_mem_be;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_busy      <= (w_next_state != c_S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                // A rejected data access stays in IDLE.
                if (w_data_win && !w_ls_bad) w_next_state = c_S_DATA;
                else if (w_fetch_win)        w_next_state = c_S_FETCH;
            end
            c_S_FETCH, c_S_DATA: begin
                if (r_mem_req && mem_ack) w_next_state = c_S_IDLE;
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt       = r_cnt;
        w_f3        = r_f3;
        w_alo       = r_alo;
        w_we        = r_we;
        w_if_ready  = 1'b0;
        w_if_rdata  = r_if_rdata;
        w_ls_ready  = 1'b0;
        w_ls_rdata  = r_ls_rdata;
        w_ls_err    = 1'b0;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_be    = r_mem_be;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        case (r_state)
            c_S_IDLE: begin
                if (w_data_win) begin
                    w_cnt = if_req ? (r_cnt + 1'b1) : '0;
                    if (w_ls_bad) begin
                        w_ls_ready = 1'b1;
                        w_ls_err   = 1'b1;
                        w_ls_rdata = 32'd0;
                    end else begin
                        w_mem_req   = 1'b1;
                        w_mem_we    = ls_we;
                        w_mem_be    = ls_we ? w_st_be : 4'b1111;
                        w_mem_addr  = {ls_addr[31:2], 2'b00};
                        w_mem_wdata = ls_we ? w_st_data : 32'd0;
                        w_f3        = ls_funct3;
                        w_alo       = ls_addr[1:0];
                        w_we        = ls_we;
                    end
                end else if (if_req) begin
                    w_cnt       = '0;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b0;
                    w_mem_be    = 4'b1111;
                    w_mem_addr  = {if_addr[31:2], 2'b00};
                    w_mem_wdata = 32'd0;
                end
            end
            c_S_FETCH: begin
                if (r_mem_req && mem_ack) begin
                    w_mem_req  = 1'b0;
                    w_if_ready = 1'b1;
                    w_if_rdata = mem_rdata;
                end
            end
            c_S_DATA: begin
                if (r_mem_req && mem_ack) begin
                    w_mem_req  = 1'b0;
                    w_ls_ready = 1'b1;
                    w_ls_rdata = r_we ? 32'd0 : w_load_val;
                end
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign ls_ready  = r_ls_ready;
    assign ls_rdata  = r_ls_rdata;
    assign ls_err    = r_ls_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: reset values, a table
//             of directed load/store vectors, fetch latency, wait-state
//             stability, fairness grant order, async reset mid-transaction
//             and randomized traffic against a byte-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk, rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.MAX_DATA_BURST(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " if_ready"},  if_ready,  0);
        chk({nm, " if_rdata"},  if_rdata,  0);
        chk({nm, " ls_ready"},  ls_ready,  0);
        chk({nm, " ls_rdata"},  ls_rdata,  0);
        chk({nm, " ls_err"},    ls_err,    0);
        chk({nm, " mem_req"},   mem_req,   0);
        chk({nm, " mem_we"},    mem_we,    0);
        chk({nm, " mem_be"},    mem_be,    0);
        chk({nm, " mem_addr"},  mem_addr,  0);
        chk({nm, " mem_wdata"}, mem_wdata, 0);
        chk({nm, " busy"},      busy,      0);
    endtask

    // Reference: the access is a little-endian window of 'size' bytes
    // starting at byte offset addr%4 of the memory word.
    function automatic void ls_model(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] mrd,
                                     output logic err, output logic [3:0] be,
                                     output logic [31:0] wd, output logic [31:0] rd);
        int size, off;
        size = 1 << f3[1:0];
        off  = int'(addr[1:0]);
        err  = 1'b0;
        if (f3[1:0] == 2'b11)                 err = 1'b1;
        if (we && f3[2])                      err = 1'b1;
        if (!we && f3 == 3'b110)              err = 1'b1;
        if (!err && (off % size) != 0)        err = 1'b1;
        be = 4'd0; wd = 32'd0; rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) be[off + k] = 1'b1;
                for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
            end else begin
                be = 4'b1111;
                for (int k = 0; k < size; k++) rd[8*k +: 8] = mrd[8*(off + k) +: 8];
                if (!f3[2] && size < 4 && rd[8*size - 1])
                    for (int k = size; k < 4; k++) rd[8*k +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic ls_txn(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mrd, input int waits);
        logic e;
        logic [3:0] be;
        logic [31:0] wd, rd, ma;
        ls_model(we, f3, addr, wdata, mrd, e, be, wd, rd);
        ma = {addr[31:2], 2'b00};
        ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
        @(posedge clk); #1;
        if (e) begin
            chk({nm, " err mem_req"},  mem_req,  0);
            chk({nm, " err ls_ready"}, ls_ready, 1);
            chk({nm, " err ls_err"},   ls_err,   1);
            chk({nm, " err ls_rdata"}, ls_rdata, 0);
            chk({nm, " err busy"},     busy,     0);
            ls_req = 1'b0;
        end else begin
            // Inputs after grant must not matter.
            ls_we = ~we; ls_funct3 = 3'($urandom); ls_addr = $urandom; ls_wdata = $urandom;
            for (int w = 0; w <= waits; w++) begin
                chk({nm, " mem_req"},  mem_req,  1);
                chk({nm, " mem_we"},   mem_we,   we);
                chk({nm, " mem_be"},   mem_be,   be);
                chk({nm, " mem_addr"}, mem_addr, ma);
                if (we) chk({nm, " mem_wdata"}, mem_wdata, wd);
                chk({nm, " ls_ready early"}, ls_ready, 0);
                chk({nm, " busy"}, busy, 1);
                if (w == waits) begin mem_ack = 1'b1; mem_rdata = mrd; end
                else begin mem_ack = 1'b0; mem_rdata = $urandom; end
                @(posedge clk); #1;
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk({nm, " ls_ready"},     ls_ready, 1);
            chk({nm, " ls_err"},       ls_err,   0);
            chk({nm, " ls_rdata"},     ls_rdata, rd);
            chk({nm, " mem_req done"}, mem_req,  0);
            chk({nm, " busy done"},    busy,     0);
            ls_req = 1'b0;
        end
        @(posedge clk); #1;
        chk({nm, " ls_ready pulse"}, ls_ready, 0);
    endtask

    task automatic fetch_txn(input string nm, input logic [31:0] addr,
                             input logic [31:0] rdat, input int waits);
        logic [31:0] ma;
        ma = {addr[31:2], 2'b00};
        if_req = 1'b1; if_addr = addr;
        @(posedge clk); #1;
        if_addr = $urandom;
        for (int w = 0; w <= waits; w++) begin
            chk({nm, " mem_req"},  mem_req,  1);
            chk({nm, " mem_we"},   mem_we,   0);
            chk({nm, " mem_be"},   mem_be,   4'hF);
            chk({nm, " mem_addr"}, mem_addr, ma);
            chk({nm, " busy"},     busy,     1);
            chk({nm, " if_ready early"}, if_ready, 0);
            if (w == waits) begin mem_ack = 1'b1; mem_rdata = rdat; end
            else begin mem_ack = 1'b0; mem_rdata = $urandom; end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk({nm, " if_ready"},     if_ready, 1);
        chk({nm, " if_rdata"},     if_rdata, rdat);
        chk({nm, " mem_req done"}, mem_req,  0);
        chk({nm, " busy done"},    busy,     0);
        chk({nm, " ls_ready"},     ls_ready, 0);
        if_req = 1'b0;
        @(posedge clk); #1;
        chk({nm, " if_ready pulse"}, if_ready, 0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          waits;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // we  f3      addr          wdata         mrd           w  err be       wd            rd
        vecs[0]  = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'hF, 32'h0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'hF, 32'h0, 32'h0000_0080};
        vecs[2]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'hF, 32'h0, 32'h0000_80FF};
        vecs[3]  = '{1'b0, 3'b001, 32'h202, 32'h0,        32'h80FF_0000, 1, 1'b0, 4'hF, 32'h0, 32'hFFFF_80FF};
        vecs[4]  = '{1'b0, 3'b010, 32'h200, 32'h0,        32'h80FF_0000, 0, 1'b0, 4'hF, 32'h0, 32'h80FF_0000};
        vecs[5]  = '{1'b0, 3'b000, 32'h201, 32'h0,        32'h1234_5678, 2, 1'b0, 4'hF, 32'h0, 32'h0000_0056};
        vecs[6]  = '{1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0,        3, 1'b0, 4'hC, 32'hABCD_ABCD, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0,        0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,        1, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 3'b001, 32'h103, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'b101, 32'h201, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0};
    end

    initial begin
        logic        e;
        logic [3:0]  be;
        logic [31:0] wd, rd;
        int          grants, mcnt;
        logic [7:0]  exp_g, act_g;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: the hand-written expectation must agree with the
        // reference model and with the DUT.
        for (int i = 0; i < 14; i++) begin
            ls_model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].mrd, e, be, wd, rd);
            chk($sformatf("vec%0d model err", i), e, vecs[i].err);
            if (!e) begin
                chk($sformatf("vec%0d model be", i), be, vecs[i].be);
                if (vecs[i].we) chk($sformatf("vec%0d model wd", i), wd, vecs[i].wd);
            end
            chk($sformatf("vec%0d model rd", i), rd, vecs[i].rd);
            ls_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
                   vecs[i].wdata, vecs[i].mrd, vecs[i].waits);
        end

        // Fetch with same-cycle ack; busy only during the memory cycle.
        chk("fetch busy before", busy, 0);
        fetch_txn("fetch1006", 32'h0000_1006, 32'h0010_0093, 0);
        fetch_txn("fetch_wait", 32'h0000_2000, 32'hCAFE_F00D, 2);

        // Fairness: both requesters held, single-cycle ack.
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h800;
        if_req = 1'b1; if_addr = 32'h400;
        grants = 0; mcnt = 0;
        for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                if (mcnt < MAX) begin exp_g = "D"; mcnt++; end
                else begin exp_g = "F"; mcnt = 0; end
                act_g = (mem_addr == 32'h400) ? 8'(70) : 8'(68);
                chk($sformatf("burst grant %0d", grants), act_g, exp_g);
                grants++;
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
        chk("burst grant count", grants, 10);
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;

        // Async reset during a store in DATA.
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h800; ls_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("pre-reset mem_req", mem_req, 1);
        chk("pre-reset mem_we",  mem_we,  1);
        #3 rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        ls_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stale ack mem_req",  mem_req,  0);
        chk("stale ack ls_ready", ls_ready, 0);
        chk("stale ack if_ready", if_ready, 0);
        chk("stale ack busy",     busy,     0);
        mem_ack = 1'b0;
        fetch_txn("post-reset fetch", 32'h0000_3008, 32'h1357_9BDF, 1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0)
                fetch_txn($sformatf("rnd%0d fetch", n), $urandom, $urandom, int'($urandom_range(0, 3)));
            else
                ls_txn($sformatf("rnd%0d ls", n), 1'($urandom), 3'($urandom_range(0, 7)),
                       $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
